// File: rtl/ex_mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_pkg : shared RISC-V funct3 / result-source encodings and widths
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ex_mem_stage_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

  localparam int RD_W_DEFAULT = 5;

  // The ALU runs SUB for BEQ/BNE and SLT/SLTU for the ordered compares,
  // so the zero flag and the result LSB are all a branch needs.
  function automatic logic branch_cond(input logic [2:0] funct3,
                                       input logic       zero,
                                       input logic       alu_lsb);
    logic cond;
    cond = 1'b0;
    case (funct3)
      F3_BEQ:           cond = zero;
      F3_BNE:           cond = !zero;
      F3_BLT, F3_BLTU:  cond = alu_lsb;
      F3_BGE, F3_BGEU:  cond = !alu_lsb;
      default:          cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_stage_branch_unit.sv
// ----------------------------------------------------------------------------
// branch_unit : combinational branch/jump taken resolution from ALU flags
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module branch_unit
  import ex_mem_stage_pkg::*;
(
  input  logic       jump,
  input  logic       branch,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       alu_lsb,
  output logic       taken
);

  assign taken = jump | (branch & branch_cond(funct3, zero, alu_lsb));

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage : EX->MEM pipeline register with valid/ready handshake and
//                branch resolution; EX_MEM_SKID_EN adds a registered-ready skid.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = RD_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_alu_out,
  input  logic             in_zero,
  input  logic             in_branch,
  input  logic             in_jump,
  input  logic [2:0]       in_funct3,
  input  logic [WIDTH-1:0] in_pc_target,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_reg_write,
  input  logic             in_mem_write,
  input  logic [1:0]       in_result_src,
  input  logic [WIDTH-1:0] in_write_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_alu_out,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_reg_write,
  output logic             out_mem_write,
  output logic [1:0]       out_result_src,
  output logic [WIDTH-1:0] out_write_data,
  output logic [WIDTH-1:0] out_pc_target,
  output logic             out_pc_src
);

  localparam int PW        = 3*WIDTH + RD_W + 5;
  localparam int TAKEN_BIT = PW - 1;

  logic          taken;
  logic          accept;
  logic [PW-1:0] in_bundle;
  logic [PW-1:0] out_bundle;

  branch_unit u_branch_unit (
    .jump    (in_jump),
    .branch  (in_branch),
    .funct3  (in_funct3),
    .zero    (in_zero),
    .alu_lsb (in_alu_out[0]),
    .taken   (taken)
  );

  assign in_bundle = {taken, in_pc_target, in_write_data, in_result_src,
                      in_mem_write, in_reg_write, in_rd, in_alu_out};
  assign {out_pc_src, out_pc_target, out_write_data, out_result_src,
          out_mem_write, out_reg_write, out_rd, out_alu_out} = out_bundle;

  assign accept = in_valid & in_ready;

`ifdef EX_MEM_SKID_EN
  logic          skid_valid;
  logic [PW-1:0] skid_bundle;

  // Ready depends only on the skid flop, breaking the out_ready->in_ready path.
  assign in_ready = !skid_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_bundle  <= '0;
      skid_valid  <= 1'b0;
      skid_bundle <= '0;
    end else if (flush) begin
      out_valid             <= 1'b0;
      out_bundle[TAKEN_BIT] <= 1'b0;
      skid_valid            <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (skid_valid) begin
        // accept is impossible here since in_ready is low while the skid holds data
        out_valid  <= 1'b1;
        out_bundle <= skid_bundle;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        out_bundle <= in_bundle;
      end else begin
        out_valid             <= 1'b0;
        out_bundle[TAKEN_BIT] <= 1'b0;
      end
    end else if (accept) begin
      skid_valid  <= 1'b1;
      skid_bundle <= in_bundle;
    end
  end
`else
  assign in_ready = !out_valid | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_bundle <= '0;
    end else if (flush) begin
      out_valid             <= 1'b0;
      out_bundle[TAKEN_BIT] <= 1'b0;
    end else if (in_ready) begin
      if (accept) begin
        out_valid  <= 1'b1;
        out_bundle <= in_bundle;
      end else begin
        out_valid             <= 1'b0;
        out_bundle[TAKEN_BIT] <= 1'b0;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage : randomized bench for ex_mem_stage against a queue model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  localparam int WIDTH = 32;
  localparam int RD_W  = 5;
`ifdef EX_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic             clk;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_alu_out;
  logic             in_zero;
  logic             in_branch;
  logic             in_jump;
  logic [2:0]       in_funct3;
  logic [WIDTH-1:0] in_pc_target;
  logic [RD_W-1:0]  in_rd;
  logic             in_reg_write;
  logic             in_mem_write;
  logic [1:0]       in_result_src;
  logic [WIDTH-1:0] in_write_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_alu_out;
  logic [RD_W-1:0]  out_rd;
  logic             out_reg_write;
  logic             out_mem_write;
  logic [1:0]       out_result_src;
  logic [WIDTH-1:0] out_write_data;
  logic [WIDTH-1:0] out_pc_target;
  logic             out_pc_src;

  ex_mem_stage #(.WIDTH(WIDTH), .RD_W(RD_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_out     (in_alu_out),
    .in_zero        (in_zero),
    .in_branch      (in_branch),
    .in_jump        (in_jump),
    .in_funct3      (in_funct3),
    .in_pc_target   (in_pc_target),
    .in_rd          (in_rd),
    .in_reg_write   (in_reg_write),
    .in_mem_write   (in_mem_write),
    .in_result_src  (in_result_src),
    .in_write_data  (in_write_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_out    (out_alu_out),
    .out_rd         (out_rd),
    .out_reg_write  (out_reg_write),
    .out_mem_write  (out_mem_write),
    .out_result_src (out_result_src),
    .out_write_data (out_write_data),
    .out_pc_target  (out_pc_target),
    .out_pc_src     (out_pc_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] wd;
    logic [RD_W-1:0]  rd;
    logic             rw;
    logic             mw;
    logic [1:0]       rs;
    logic             taken;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic last_ready;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic ref_taken();
    logic alu_odd;
    alu_odd = (in_alu_out % 2) == 1;
    if (in_jump) return 1'b1;
    if (!in_branch) return 1'b0;
    if (in_funct3 == F3_BEQ) return in_zero;
    if (in_funct3 == F3_BNE) return !in_zero;
    if (in_funct3 == F3_BLT || in_funct3 == F3_BLTU) return alu_odd;
    if (in_funct3 == F3_BGE || in_funct3 == F3_BGEU) return !alu_odd;
    return 1'b0;
  endfunction

  function automatic ent_t cur_in();
    ent_t e;
    e.alu = in_alu_out; e.pc = in_pc_target; e.wd = in_write_data; e.rd = in_rd;
    e.rw = in_reg_write; e.mw = in_mem_write; e.rs = in_result_src; e.taken = ref_taken();
    return e;
  endfunction

  function automatic ent_t dut_out();
    ent_t e;
    e.alu = out_alu_out; e.pc = out_pc_target; e.wd = out_write_data; e.rd = out_rd;
    e.rw = out_reg_write; e.mw = out_mem_write; e.rs = out_result_src; e.taken = out_pc_src;
    return e;
  endfunction

  // Called just after a negedge with the inputs for this cycle already driven.
  task automatic step();
    logic exp_ready;
    exp_ready = (CAP == 2) ? (q.size() < 2) : (q.size() == 0 || out_ready);
    #1;
    check("in_ready", in_ready, exp_ready);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) check("payload", dut_out(), q[0]);
    else check("pc_src_idle", out_pc_src, 1'b0);
    last_ready = exp_ready;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) q.push_back(cur_in());
    end
    @(negedge clk);
  endtask

  task automatic rand_payload();
    in_alu_out    = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 1)) : $urandom;
    in_zero       = (in_alu_out == 0);
    in_branch     = $urandom_range(0, 1);
    in_jump       = ($urandom_range(0, 5) == 0);
    in_funct3     = 3'($urandom_range(0, 7));
    in_pc_target  = $urandom;
    in_rd         = RD_W'($urandom);
    in_reg_write  = $urandom_range(0, 1);
    in_mem_write  = $urandom_range(0, 1);
    in_result_src = 2'($urandom_range(0, 2));
    in_write_data = $urandom;
  endtask

  task automatic set_branch(input logic [2:0] f3, input logic [WIDTH-1:0] alu, input logic [WIDTH-1:0] pc);
    rand_payload();
    in_valid = 1'b1; in_branch = 1'b1; in_jump = 1'b0;
    in_funct3 = f3; in_alu_out = alu; in_zero = (alu == 0); in_pc_target = pc;
  endtask

  initial begin
    int acc;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    rand_payload();
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", out_valid, 1'b0);
    check("reset_payload", dut_out(), '0);
    reset_n = 1'b1;
    @(negedge clk);

    // BEQ taken, target passes through
    set_branch(F3_BEQ, 32'd0, 32'h0000_1000);
    step();
    check("beq_valid", out_valid, 1'b1);
    check("beq_taken", out_pc_src, 1'b1);
    check("beq_target", out_pc_target, 32'h0000_1000);

    set_branch(F3_BLTU, 32'd1, 32'h0000_2000);
    step();
    check("bltu_taken", out_pc_src, 1'b1);
    set_branch(F3_BGEU, 32'd1, 32'h0000_3000);
    step();
    check("bgeu_not_taken", out_pc_src, 1'b0);
    set_branch(3'b010, 32'd1, 32'h0000_4000);
    step();
    check("f3_010_not_taken", out_pc_src, 1'b0);
    in_valid = 1'b0;
    step();

    // Back-to-back stream
    for (int i = 0; i < 8; i++) begin
      rand_payload(); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();

    // Stall with input pending
    acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_payload(); in_valid = 1'b1;
      step();
      if (last_ready) acc++;
    end
    check("stall_accepts", acc, CAP);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    // Flush with everything full and a new input offered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_payload(); in_valid = 1'b1;
      step();
    end
    rand_payload(); flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_valid", out_valid, 1'b0);
    repeat (3) step();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      rand_payload();
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    flush = 1'b0;

    // Asynchronous reset with entries in flight
    out_ready = 1'b0;
    repeat (2) begin
      rand_payload(); in_valid = 1'b1;
      step();
    end
    #2 reset_n = 1'b0;
    #1;
    check("areset_valid", out_valid, 1'b0);
    check("areset_pc_src", out_pc_src, 1'b0);
    check("areset_payload", dut_out(), '0);
    q.delete();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      rand_payload();
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
